riscv_lsu: RTL and testbench

- Parametrised load/store unit between the single-cycle core's execute results and the data cache or memory port.
- Replaces the core's direct MemRead/MemWrite/Storetype strobes with a valid/ready memory handshake.
- Produces byte enables, and performs sign/zero load extension.
- Splits misaligned accesses into two aligned beats. The core is held with `stall` until the access completes.

---
 rtl/riscv_lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/riscv_lsu.sv | 154 +++++++++++++++
 tb/tb_riscv_lsu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, size helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_t;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte-enable mask, store data lane shift, load extract and extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]       size,
    input  logic [OFF_W-1:0] offset,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata_lo,
    input  logic [XLEN-1:0]  rdata_hi,
    output logic [NB-1:0]    be_lo,
    output logic [NB-1:0]    be_hi,
    output logic [XLEN-1:0]  wdata_lo,
    output logic [XLEN-1:0]  wdata_hi,
    output logic [XLEN-1:0]  load_data
);

    localparam logic [2*NB-1:0] ONE_M = 1;

    logic [6:0]        bit_shift;
    logic [2*NB-1:0]   byte_mask;
    logic [2*XLEN-1:0] wdata_wide;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   keep;
    logic              sign_bit;

    // Mask and data are formed across two beats' worth of lanes, then split into halves.
    always_comb begin
        bit_shift  = 7'(offset) << 3;
        byte_mask  = ((ONE_M << size_bytes(size)) - ONE_M) << offset;
        wdata_wide = {{XLEN{1'b0}}, wdata} << bit_shift;
        rd_shift   = XLEN'({rdata_hi, rdata_lo} >> bit_shift);
        // keep = ones over the loaded width; shifting by the full width yields all-ones
        keep       = ~({XLEN{1'b1}} << {size_bytes(size), 3'b000});
        case (size)
            SZ_B:    sign_bit = rd_shift[7];
            SZ_H:    sign_bit = rd_shift[15];
            SZ_W:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[XLEN-1];
        endcase
        load_data  = (rd_shift & keep) | (~keep & {XLEN{sign_bit & ~is_unsigned}});
    end

    assign be_lo    = byte_mask[NB-1:0];
    assign be_hi    = byte_mask[2*NB-1:NB];
    assign wdata_lo = wdata_wide[XLEN-1:0];
    assign wdata_hi = wdata_wide[2*XLEN-1:XLEN];

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns a core access into one or two aligned valid/ready memory beats.
// Latency: aligned store 2 cycles, aligned load 3 cycles, fault 1 cycle, plus beats/waits.
// Backpressure: holds each beat on mem_valid until mem_ready; stalls the core meanwhile.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t        state, state_nxt;
    logic              beat, two_beats;
    logic              r_we, r_uns, r_fault;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata, rdata_lo, rdata_hi;

    logic              req_two, req_fault, accept, beat_done, next_beat;
    logic [ADDR_W-1:0] base_addr;
    logic [NB-1:0]     be_lo, be_hi;
    logic [XLEN-1:0]   wd_lo, wd_hi, load_data;

    // An access crosses a lane boundary when its last byte lands past the word.
    assign req_two   = (5'(req_addr[OFF_W-1:0]) + 5'(size_bytes(req_size))) > 5'(NB);
    assign req_fault = ((req_size == SZ_D) && (XLEN == 32)) ||
                       (req_two && (MISALIGN_SPLIT == 0));
    assign accept    = (state == IDLE) && req_valid;
    assign beat_done = ((state == ISSUE) && mem_ready && r_we) ||
                       ((state == WAIT) && mem_rvalid);
    assign next_beat = beat_done && two_beats && !beat;
    assign base_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lsu_align #(.XLEN(XLEN)) u_align (
        .size        (r_size),
        .offset      (r_addr[OFF_W-1:0]),
        .is_unsigned (r_uns),
        .wdata       (r_wdata),
        .rdata_lo    (rdata_lo),
        .rdata_hi    (rdata_hi),
        .be_lo       (be_lo),
        .be_hi       (be_hi),
        .wdata_lo    (wd_lo),
        .wdata_hi    (wd_hi),
        .load_data   (load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: faults skip memory; a second beat loops back to ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = req_fault ? DONE : ISSUE;
            ISSUE:   if (mem_ready)  state_nxt = !r_we ? WAIT : (next_beat ? ISSUE : DONE);
            WAIT:    if (mem_rvalid) state_nxt = next_beat ? ISSUE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, beat index and read-beat data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= 1'b0;
            two_beats <= 1'b0;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_fault   <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            rdata_lo  <= '0;
            rdata_hi  <= '0;
        end else begin
            if (accept) begin
                r_we      <= req_we;
                r_uns     <= req_unsigned;
                r_size    <= req_size;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                two_beats <= req_two;
                r_fault   <= req_fault;
                beat      <= 1'b0;
            end else if (next_beat) begin
                beat <= 1'b1;
            end
            if ((state == WAIT) && mem_rvalid) begin
                if (beat) rdata_hi <= mem_rdata;
                else      rdata_lo <= mem_rdata;
            end
        end
    end

    // Outputs decoded from state; beat fields are zero outside ISSUE, stall drops during reset.
    always_comb begin
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_rdata = '0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state)
            IDLE:  stall = req_valid & ~rst;
            ISSUE: begin
                stall     = 1'b1;
                mem_valid = 1'b1;
                mem_we    = r_we;
                mem_addr  = beat ? base_addr + ADDR_W'(NB) : base_addr;
                mem_be    = beat ? be_hi : be_lo;
                mem_wdata = beat ? wd_hi : wd_lo;
            end
            WAIT:  stall = 1'b1;
            DONE: begin
                rsp_valid = 1'b1;
                rsp_fault = r_fault;
                rsp_rdata = (r_fault || r_we) ? '0 : load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed cases plus random accesses against a byte-level memory model.
// Latency: n/a.
// Backpressure: bench drives mem_ready/mem_rvalid with programmable delays.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        ns_req_valid, ns_stall, ns_rsp_valid, ns_rsp_fault;
    logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata;
    logic        ns_mem_valid, ns_mem_we;
    logic [3:0]  ns_mem_be;
    logic        ns_mem_ready, ns_mem_rvalid;
    logic [31:0] ns_mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  bmem [logic [31:0]];
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_wd [2];
    logic [31:0] last_rdata;
    int          last_lat;
    bit          got;

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(ns_stall), .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_fault(ns_rsp_fault),
        .mem_valid(ns_mem_valid), .mem_ready(ns_mem_ready), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
        .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_rvalid(ns_mem_rvalid), .mem_rdata(ns_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // One access: the model lists which bytes go to which word, then the bench plays memory.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int rd_dly, input int rv_dly);
        int          n, nbeats, bi, wcnt, rvcnt, cyc, exp_lat, lane, b;
        bit          fault, pend, done;
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] a, pend_addr, lane_mask, exp_rd;
        logic [63:0] v;

        n           = 1 << size;
        fault       = (size == 2'd3);
        nbeats      = 0;
        exp_addr[0] = addr & ~32'd3;
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_be[0]   = '0; exp_be[1] = '0;
        exp_wd[0]   = '0; exp_wd[1] = '0;
        v           = '0;
        if (!fault) begin
            for (int i = 0; i < n; i++) begin
                a    = addr + 32'(i);
                b    = ((a & ~32'd3) == exp_addr[0]) ? 0 : 1;
                lane = int'(a[1:0]);
                exp_be[b][lane] = 1'b1;
                exp_wd[b][8*lane +: 8] = wdata[8*i +: 8];
                v[8*i +: 8] = rd_byte(a);
                if (b + 1 > nbeats) nbeats = b + 1;
            end
            if (!uns && v[8*n-1]) for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        end
        exp_rd  = (fault || we) ? 32'h0 : v[31:0];
        exp_lat = fault ? 1 : 1 + nbeats * (1 + rd_dly) + (we ? 0 : nbeats * rv_dly);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("stall_on_req", stall, 1);
        cyc = 0; bi = 0; wcnt = 0; pend = 0; rvcnt = 0; done = 0; pend_addr = '0;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (rsp_valid) begin
                done = 1;
                last_lat = cyc; last_rdata = rsp_rdata;
                check("latency", cyc, exp_lat);
                check("rsp_fault", rsp_fault, fault);
                check("stall_done", stall, 0);
                check("beats", bi, nbeats);
                if (!we) check("rsp_rdata", rsp_rdata, exp_rd);
            end else begin
                check("stall_busy", stall, 1);
                if (pend) begin
                    rvcnt--;
                    if (rvcnt == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rd_word(pend_addr); pend = 0;
                    end
                end
                if (mem_valid) begin
                    if (bi < nbeats) begin
                        lane_mask = {{8{exp_be[bi][3]}}, {8{exp_be[bi][2]}}, {8{exp_be[bi][1]}}, {8{exp_be[bi][0]}}};
                        check("beat_addr", mem_addr, exp_addr[bi]);
                        check("beat_be", mem_be, exp_be[bi]);
                        check("beat_we", mem_we, we);
                        if (we) check("beat_wdata", mem_wdata & lane_mask, exp_wd[bi]);
                    end else begin
                        check("extra_beat", mem_valid, 0);
                    end
                    if (wcnt < rd_dly) begin
                        wcnt++;
                    end else begin
                        mem_ready = 1'b1;
                        if (bi < 2) begin
                            obs_addr[bi] = mem_addr; obs_be[bi] = mem_be; obs_wd[bi] = mem_wdata;
                        end
                        if (!we) begin pend = 1; rvcnt = rv_dly; pend_addr = mem_addr; end
                        bi++; wcnt = 0;
                    end
                end
            end
        end
        if (!done) check("rsp_timeout", done, 1);
        if (we && !fault) for (int i = 0; i < n; i++) bmem[addr + 32'(i)] = wdata[8*i +: 8];
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        check("idle_stall", stall, 0);
        check("idle_mem_valid", mem_valid, 0);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        ns_req_valid = 0; ns_mem_ready = 1'b1; ns_mem_rvalid = 1'b0; ns_mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fault", rsp_fault, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned SW
        do_access(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 0, 1);
        check("sw_addr", obs_addr[0], 32'h1000);
        check("sw_be", obs_be[0], 4'hF);
        check("sw_wdata", obs_wd[0], 32'hDEADBEEF);
        check("sw_lat", last_lat, 2);

        // LB / LBU on the top byte lane
        put_word(32'h1000, 32'h80FF0000);
        do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 0, 1);
        check("lb_rdata", last_rdata, 32'hFFFFFF80);
        check("lb_be", obs_be[0], 4'b1000);
        check("lb_lat", last_lat, 3);
        do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 1);
        check("lbu_rdata", last_rdata, 32'h00000080);

        // Misaligned LW split over two beats
        put_word(32'h1000, 32'h44332211);
        put_word(32'h1004, 32'h88776655);
        do_access(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 1, 2);
        check("lw_split_a0", obs_addr[0], 32'h1000);
        check("lw_split_be0", obs_be[0], 4'b1100);
        check("lw_split_a1", obs_addr[1], 32'h1004);
        check("lw_split_be1", obs_be[1], 4'b0011);
        check("lw_split_rdata", last_rdata, 32'h66554433);

        // Misaligned SH with ready held low
        do_access(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000ABCD, 3, 1);
        check("sh_a0", obs_addr[0], 32'h1000);
        check("sh_be0", obs_be[0], 4'b1000);
        check("sh_wd0", obs_wd[0], 32'hCD000000);
        check("sh_a1", obs_addr[1], 32'h1004);
        check("sh_be1", obs_be[1], 4'b0001);
        check("sh_wd1", obs_wd[1], 32'h000000AB);

        // Split disabled: misaligned LW faults without traffic
        @(negedge clk);
        req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h1001; ns_req_valid = 1'b1;
        #1;
        check("ns_stall_req", ns_stall, 1);
        got = 0;
        for (int k = 1; k <= 4 && !got; k++) begin
            @(negedge clk);
            check("ns_no_beat", ns_mem_valid, 0);
            if (ns_rsp_valid) begin
                got = 1;
                check("ns_lat", k, 1);
                check("ns_fault", ns_rsp_fault, 1);
                check("ns_rdata", ns_rsp_rdata, 0);
            end
        end
        check("ns_rsp_seen", got, 1);
        @(negedge clk);
        ns_req_valid = 1'b0;

        // Dword on a 32-bit core faults
        do_access(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 0, 1);

        // Address wrap on the second beat
        do_access(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h12345678, 0, 1);
        check("wrap_a0", obs_addr[0], 32'hFFFFFFFC);
        check("wrap_a1", obs_addr[1], 32'h00000000);
        check("wrap_be1", obs_be[1], 4'b0011);

        // Reset while waiting for read data
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h1000;
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_issue", mem_valid, 1);
        @(negedge clk);
        check("rstw_wait_stall", stall, 1);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rstw_mem_valid", mem_valid, 0);
        check("rstw_stall", stall, 0);
        check("rstw_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        do_access(1'b1, 2'd0, 1'b0, 32'h2001, 32'h0000005A, 0, 1);
        check("sb_be", obs_be[0], 4'b0010);
        check("sb_wdata", obs_wd[0], 32'h00005A00);

        // Random mix, stores then loads land in the same small window
        for (int t = 0; t < 60; t++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      32'h3000 + 32'($urandom_range(0, 15)), $urandom,
                      $urandom_range(0, 2), $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
